// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/DM requesters, the shared memory and the arbiter.
// The arbiter connects through the slave modport; requesters and the memory use master.
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data
// memory requesters: round-robin grant, fixed LAT-cycle access, one-cycle ack.
module mem_port_arbiter #(
  parameter int AW  = 10,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  localparam int CW = $clog2(LAT) + 1;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          last_gnt;
  logic          any_req;
  logic          gnt_dm;

  // On a tie the requester that did not win last time takes the port.
  always_comb begin
    any_req = bus.if_req | bus.dm_req;
    gnt_dm  = bus.dm_req & (~bus.if_req | (last_gnt == OWN_IF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      owner         <= OWN_IF;
      last_gnt      <= OWN_DM;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= gnt_dm;
            last_gnt   <= gnt_dm;
            bus.mem_en <= 1'b1;
            bus.busy   <= 1'b1;
            cnt        <= CW'(LAT - 1);
            state      <= ACCESS;
            if (gnt_dm) begin
              bus.mem_addr  <= bus.dm_addr;
              bus.mem_wdata <= bus.dm_wdata;
              bus.mem_we    <= bus.dm_we;
            end else begin
              bus.mem_addr  <= bus.if_addr;
              bus.mem_we    <= 1'b0;
            end
          end
        end

        // Address, data and write enable stay put for all LAT cycles.
        ACCESS: begin
          if (cnt == '0) begin
            if (!bus.mem_we) begin
              if (owner == OWN_DM) bus.dm_rdata <= bus.mem_rdata;
              else                 bus.if_rdata <= bus.mem_rdata;
            end
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RESP: begin
          if (owner == OWN_DM) bus.dm_ack <= 1'b1;
          else                 bus.if_ack <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LAT=2 instance driven from a vector table
// plus hand sequences, and a LAT=1 instance for the short-latency read.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  logic [31:0] memval_a;
  logic [31:0] memval_b;

  mem_port_arbiter_if #(.AW(10), .DW(32)) bus_a ();
  mem_port_arbiter_if #(.AW(10), .DW(32)) bus_b ();

  mem_port_arbiter #(.AW(10), .DW(32), .LAT(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_port_arbiter #(.AW(10), .DW(32), .LAT(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Memory returns the programmed word only while enabled, garbage otherwise.
  assign bus_a.mem_rdata = bus_a.mem_en ? memval_a : 32'hBAD0BAD0;
  assign bus_b.mem_rdata = bus_b.mem_en ? memval_b : 32'hBAD0BAD0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] memval;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, " mem_en"},    64'(bus_a.mem_en),    64'd0);
    chk({tag, " mem_we"},    64'(bus_a.mem_we),    64'd0);
    chk({tag, " busy"},      64'(bus_a.busy),      64'd0);
    chk({tag, " if_ack"},    64'(bus_a.if_ack),    64'd0);
    chk({tag, " dm_ack"},    64'(bus_a.dm_ack),    64'd0);
    chk({tag, " mem_addr"},  64'(bus_a.mem_addr),  64'd0);
    chk({tag, " mem_wdata"}, 64'(bus_a.mem_wdata), 64'd0);
    chk({tag, " if_rdata"},  64'(bus_a.if_rdata),  64'd0);
    chk({tag, " dm_rdata"},  64'(bus_a.dm_rdata),  64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated access on the LAT=2 instance; req is dropped right after ack.
  task automatic do_txn(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    memval_a       = v.memval;
    bus_a.if_req   = ~v.is_dm;
    bus_a.if_addr  = v.is_dm ? 10'h2AA : v.addr;
    bus_a.dm_req   = v.is_dm;
    bus_a.dm_we    = v.we;
    bus_a.dm_addr  = v.is_dm ? v.addr : 10'h155;
    bus_a.dm_wdata = v.wdata;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk({tag, " access mem_en"},   64'(bus_a.mem_en),   64'd1);
      chk({tag, " access mem_we"},   64'(bus_a.mem_we),   64'(v.is_dm & v.we));
      chk({tag, " access mem_addr"}, 64'(bus_a.mem_addr), 64'(v.addr));
      chk({tag, " access busy"},     64'(bus_a.busy),     64'd1);
      chk({tag, " access acks"},     64'({bus_a.if_ack, bus_a.dm_ack}), 64'd0);
      if (v.is_dm && v.we)
        chk({tag, " access mem_wdata"}, 64'(bus_a.mem_wdata), 64'(v.wdata));
    end
    @(posedge clk);
    #1;
    chk({tag, " resp mem_en"}, 64'(bus_a.mem_en), 64'd0);
    chk({tag, " resp mem_we"}, 64'(bus_a.mem_we), 64'd0);
    chk({tag, " resp acks"},   64'({bus_a.if_ack, bus_a.dm_ack}), 64'd0);
    chk({tag, " resp busy"},   64'(bus_a.busy),   64'd1);
    @(posedge clk);
    #1;
    chk({tag, " ack"}, 64'({bus_a.if_ack, bus_a.dm_ack}), v.is_dm ? 64'd1 : 64'd2);
    chk({tag, " ack busy"}, 64'(bus_a.busy), 64'd0);
    bus_a.if_req = 1'b0;
    bus_a.dm_req = 1'b0;
    bus_a.dm_we  = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " after acks"}, 64'({bus_a.if_ack, bus_a.dm_ack}), 64'd0);
    chk({tag, " after busy"}, 64'(bus_a.busy),     64'd0);
    chk({tag, " mem_addr hold"}, 64'(bus_a.mem_addr), 64'(v.addr));
    chk({tag, " if_rdata"},   64'(bus_a.if_rdata), 64'(v.exp_if));
    chk({tag, " dm_rdata"},   64'(bus_a.dm_rdata), 64'(v.exp_dm));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    memval_a = 32'h0;
    memval_b = 32'h0;
    bus_a.if_req = 1'b0; bus_a.if_addr = '0; bus_a.dm_req = 1'b0;
    bus_a.dm_we  = 1'b0; bus_a.dm_addr = '0; bus_a.dm_wdata = '0;
    bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.dm_req = 1'b0;
    bus_b.dm_we  = 1'b0; bus_b.dm_addr = '0; bus_b.dm_wdata = '0;

    //              is_dm we    addr     wdata          memval         exp_if         exp_dm
    vecs[0] = '{1'b0, 1'b0, 10'h010, 32'h00000000, 32'h2402000A, 32'h2402000A, 32'h00000000};
    vecs[1] = '{1'b1, 1'b1, 10'h004, 32'hDEADBEEF, 32'h11111111, 32'h2402000A, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 10'h123, 32'h0BADF00D, 32'hCAFEF00D, 32'h2402000A, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b0, 10'h3FF, 32'h00000000, 32'h00000001, 32'h00000001, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b1, 10'h000, 32'h12345678, 32'h87654321, 32'h00000001, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 10'h3FF, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};

    repeat (2) @(posedge clk);
    #1;
    check_reset_a("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_a("idle after reset");

    for (int i = 0; i < 6; i++) do_txn(i, vecs[i]);

    // Both requesters held: alternating grants IF, DM, IF, DM every 4 cycles.
    do_reset();
    memval_a = 32'h5A5A5A5A;
    bus_a.if_req = 1'b1; bus_a.if_addr = 10'h100;
    bus_a.dm_req = 1'b1; bus_a.dm_addr = 10'h200; bus_a.dm_we = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("rr if_ack k=%0d", k), 64'(bus_a.if_ack), 64'((k == 3) || (k == 11)));
      chk($sformatf("rr dm_ack k=%0d", k), 64'(bus_a.dm_ack), 64'((k == 7) || (k == 15)));
      if ((k % 4) < 2)
        chk($sformatf("rr mem_addr k=%0d", k), 64'(bus_a.mem_addr),
            ((k / 4) % 2 == 0) ? 64'h100 : 64'h200);
    end
    bus_a.if_req = 1'b0;
    bus_a.dm_req = 1'b0;

    // Single requester held high: ack every LAT+2 cycles, RESP between accesses.
    do_reset();
    memval_a = 32'h0000BEEF;
    bus_a.if_req = 1'b1; bus_a.if_addr = 10'h0AB;
    @(posedge clk);
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("single mem_en k=%0d", k), 64'(bus_a.mem_en), 64'((k % 4) < 2));
      chk($sformatf("single if_ack k=%0d", k), 64'(bus_a.if_ack), 64'((k % 4) == 3));
      chk($sformatf("single busy k=%0d", k),   64'(bus_a.busy),   64'((k % 4) != 3));
    end
    bus_a.if_req = 1'b0;
    @(posedge clk);
    #1;
    chk("single if_rdata", 64'(bus_a.if_rdata), 64'h0000BEEF);

    // Asynchronous reset in the second ACCESS cycle drops the access.
    @(negedge clk);
    memval_a = 32'h77777777;
    bus_a.if_req = 1'b1; bus_a.if_addr = 10'h077;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre-rst mem_en", 64'(bus_a.mem_en), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_a("async rst");
    bus_a.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-rst idle k=%0d", k),
          64'({bus_a.mem_en, bus_a.busy, bus_a.if_ack, bus_a.dm_ack}), 64'd0);
    end

    // LAT=1 instance: DM read of the top word.
    @(negedge clk);
    memval_b = 32'h00000001;
    bus_b.dm_req = 1'b1; bus_b.dm_we = 1'b0; bus_b.dm_addr = 10'h3FF;
    @(posedge clk);
    #1;
    chk("lat1 k0 mem_en",   64'(bus_b.mem_en),   64'd1);
    chk("lat1 k0 mem_addr", 64'(bus_b.mem_addr), 64'h3FF);
    @(posedge clk);
    #1;
    chk("lat1 k1 mem_en", 64'(bus_b.mem_en), 64'd0);
    chk("lat1 k1 dm_ack", 64'(bus_b.dm_ack), 64'd0);
    @(posedge clk);
    #1;
    chk("lat1 k2 dm_ack",   64'(bus_b.dm_ack),   64'd1);
    chk("lat1 k2 if_ack",   64'(bus_b.if_ack),   64'd0);
    chk("lat1 k2 dm_rdata", 64'(bus_b.dm_rdata), 64'h00000001);
    bus_b.dm_req = 1'b0;
    @(posedge clk);
    #1;
    chk("lat1 k3 dm_ack", 64'(bus_b.dm_ack), 64'd0);
    chk("lat1 k3 busy",   64'(bus_b.busy),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
